scan_register_bank: RTL
=======================

# scan_register_bank

Parametrised scannable register bank: a WIDTH-bit register with hold, parallel load, serial scan shift and synchronous clear modes. It generalises the single-bit synchronous scanned D flip-flop to a full scan chain segment with shift counting. Instances sit on datapath pipeline boundaries and are daisy-chained through `d1`/`scan_out` to form a design-wide scan chain.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range is 2 or more.
- `RESET_VAL`, default all-zero WIDTH-bit value: value loaded into `q` on reset.
- `CW`, derived, not overridable: `$clog2(WIDTH)`; width of the shift counter.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `mode`, input, 2: operation select. 00 = hold, 01 = parallel load, 10 = scan shift, 11 = synchronous clear.
- `d0`, input, WIDTH: parallel (functional) data input.
- `d1`, input, 1: serial scan input; enters `q[0]`.
- `q`, output, WIDTH: register contents.
- `scan_out`, output, 1: serial scan output; equals `q[WIDTH-1]`, combinational from `q`.
- `shift_cnt`, output, CW: number of scan shifts since the last load, clear or wrap, modulo WIDTH.
- `scan_done`, output, 1: registered one-cycle pulse marking completion of a full WIDTH-bit scan.
- `parity`, output, 1: even parity of `q`. Present only when `SCAN_PARITY_EN` is defined.

## Operation
- Reset is asserted when `rst` = 0 and takes effect immediately, with no dependency on `clk`. While reset is asserted:
  - `q` = RESET_VAL
  - `shift_cnt` = 0
  - `scan_done` = 0
  - `parity` = ^RESET_VAL
- Register updates at each rising edge of `clk`, with `rst` = 1:
  - **Hold (00):** `q` and `shift_cnt` keep their values; `scan_done` <= 0.
  - **Load (01):** `q` <= `d0`; `shift_cnt` <= 0; `scan_done` <= 0.
  - **Shift (10):** `q` <= {`q[WIDTH-2:0]`, `d1`}.
    - If `shift_cnt` = WIDTH-1: `shift_cnt` <= 0 and `scan_done` <= 1.
    - Otherwise: `shift_cnt` <= `shift_cnt`+1 and `scan_done` <= 0.
  - **Clear (11):** `q` <= 0; `shift_cnt` <= 0; `scan_done` <= 0. Clear always writes 0, not RESET_VAL.
- Shift counting is cumulative across hold cycles. Shifts interleaved with holds still complete a scan after WIDTH shift cycles in total.
- Load or clear abandons a partial scan: the count restarts at 0 and no `scan_done` pulse is produced.
- Mode is a strict encoding, so no two operations are ever active in the same cycle.
- If `mode` is X or Z at a clock edge, `q` and `shift_cnt` become X. The bench must never drive `mode` unknown outside reset.
- `scan_out` reflects the shifted-out bit: the value `q[WIDTH-1]` held before a shift edge is what the downstream stage captures on that edge.

## Timing
- Latency:
  - Load, clear and shift: one cycle. `q` shows the new value after the edge where the mode was sampled.
  - `scan_done`: asserted in the cycle after the WIDTH-th shift edge, for exactly one cycle.
- Back-to-back full scans give a `scan_done` pulse every WIDTH cycles.
- Inputs `mode`, `d0` and `d1` must be stable from Tsetup before to Thold after each rising edge. Bench values: Tsetup = 5, Thold = 5, clock period 100.
- Reset asserted in the middle of a scan:
  - Effect is immediate: `q` = RESET_VAL, `shift_cnt` = 0, and any pending `scan_done` is dropped.
  - Deassertion must meet recovery time to the next rising edge.
  - The first edge after deassertion executes normally according to `mode`.

## Configuration
- Macro: `SCAN_PARITY_EN`.
- **Defined:**
  - A `parity` register is added and updated on every edge as `^`(next value of `q`), so `parity` always equals `^q` in the same cycle.
  - Reset value is ^RESET_VAL.
- **Undefined:** the `parity` port and its register are absent. All other behaviour is identical.

## Test plan
Use WIDTH = 8 and RESET_VAL = 8'hA5.
1. **Reset:** drive `rst` = 0 mid-cycle with `mode` = 10 -> immediately `q` = A5, `shift_cnt` = 0, `scan_done` = 0, and `parity` = 0 when enabled.
2. **Load:** `mode` = 01, `d0` = 3C for one edge -> `q` = 3C and `shift_cnt` = 0 after the edge. Then `mode` = 00 for 3 edges -> `q` stays 3C.
3. **Full scan:** load 3C, then 8 shift edges with `d1` = 1,0,1,1,0,0,1,0 ->
   - `scan_out` sequence = 0,0,1,1,1,1,0,0
   - final `q` = B2
   - `shift_cnt` returns to 0
   - `scan_done` = 1 for exactly the one cycle after edge 8.
4. **Interleaved and abandoned scan:**
   - 5 shifts, 2 holds, 3 shifts -> `scan_done` pulses after the 8th shift.
   - Separately, 5 shifts then a load of 00 -> `shift_cnt` = 0 and no pulse follows 3 further shifts.
5. **Clear and reset mid-scan:**
   - `mode` = 11 with `q` = FF -> `q` = 00.
   - Reset asserted at `shift_cnt` = 4 -> `q` = A5 and `shift_cnt` = 0; after release, 8 shifts produce a single `scan_done`.
6. **Parity (SCAN_PARITY_EN defined):** load 07 -> `parity` = 1; shift in 1 -> `q` = 0F, `parity` = 0.

Source files
------------

// File: rtl/scan_register_bank.sv
// scan_register_bank: WIDTH-bit scannable register with hold, parallel load,
// serial scan shift and synchronous clear modes, plus a modulo-WIDTH shift
// counter that flags each completed full-width scan.
// Optional feature macro: SCAN_PARITY_EN adds a registered even-parity output.
//
// Output signalling: scan_done is a one-cycle strobe with no back-pressure.
// It is high in the cycle that follows the WIDTH-th accumulated shift edge,
// and any consumer must sample it in that cycle.
module scan_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d0,
  input  logic             d1,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             scan_done
`ifdef SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state selection for data, shift counter and completion strobe.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    case (mode)
      MODE_HOLD: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
      MODE_LOAD: begin
        q_d   = d0;
        cnt_d = '0;
      end
      MODE_SHIFT: begin
        q_d = {q_q[WIDTH-2:0], d1};
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MODE_CLEAR: begin
        // Clear writes zero, deliberately not RESET_VAL.
        q_d   = '0;
        cnt_d = '0;
      end
      default: begin
        // Unknown mode poisons the state so the problem is visible in simulation.
        q_d   = 'x;
        cnt_d = 'x;
      end
    endcase
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity_q;

  // Parity follows the next value of q so it always matches ^q in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= ^RESET_VAL;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q         = q_q;
  assign shift_cnt = cnt_q;
  assign scan_done = done_q;
  // The downstream stage captures the pre-edge MSB on each shift edge.
  assign scan_out  = q_q[WIDTH-1];

endmodule
